bakraid_palette: RTL and testbench

Palette stage directly downstream of the colour mixer. Takes the 11-bit mixed pixel index on each pixel-enable strobe, looks it up in a 2048 x 16 palette RAM and drives 8-bit R/G/B to the video output, blanked outside the active area. The 68000 side reads and writes the same RAM through a second port with a CS/ACK handshake.

---
 rtl/bakraid_video_pkg.sv | 30 +++
 rtl/bakraid_pal_dpram.sv | 41 ++++
 rtl/bakraid_palette.sv | 153 +++++++++++++++
 tb/tb_bakraid_palette.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bakraid_video_pkg.sv
// Shared definitions for the Bakraid video back end.
//   PAL_AW / PAL_DW    : palette address and word widths
//   R_LSB/G_LSB/B_LSB  : colour field offsets within a palette word (xBBBBBGGGGGRRRRR)
//   CW                 : colour field width
//   cpu_state_t        : CPU palette access FSM states
//   expand5to8         : 5-bit to 8-bit colour expansion
package bakraid_video_pkg;

    localparam int PAL_AW = 11;
    localparam int PAL_DW = 16;

    localparam int R_LSB = 0;
    localparam int G_LSB = 5;
    localparam int B_LSB = 10;
    localparam int CW    = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OP    = 2'd1,
        S_RDCAP = 2'd2,
        S_ACK   = 2'd3
    } cpu_state_t;

    // Replicating the top bits into the low bits maps 0x00 -> 0x00 and
    // 0x1F -> 0xFF, so full scale stays full scale.
    function automatic logic [7:0] expand5to8(input logic [CW-1:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/bakraid_pal_dpram.sv
// True dual-port palette RAM, read-first on both ports.
//   clk            : clock, all accesses on rising edge
//   a_en/a_addr    : port A read-only lookup; a_q registered read data
//   b_en/b_we/b_be : port B access strobe, write select, byte enables {hi, lo}
//   b_addr/b_din   : port B address and write data; b_q registered read data
// Contents are not reset.
module bakraid_pal_dpram #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic [AW-1:0] a_addr,
    output logic [DW-1:0] a_q,
    input  logic          b_en,
    input  logic          b_we,
    input  logic [1:0]    b_be,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic [DW-1:0] b_q
);

    localparam int HW = DW / 2;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Non-blocking reads sample the array before this edge's write lands,
    // which gives read-first behaviour on an A/B address collision.
    always_ff @(posedge clk) begin
        if (a_en) a_q <= mem[a_addr];
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            b_q <= mem[b_addr];
            if (b_we && b_be[1]) mem[b_addr][DW-1:HW] <= b_din[DW-1:HW];
            if (b_we && b_be[0]) mem[b_addr][HW-1:0]  <= b_din[HW-1:0];
        end
    end

endmodule

// File: rtl/bakraid_palette.sv
// Palette stage: 11-bit mixed index -> palette RAM lookup -> 8-bit RGB,
// plus a CPU read/write port with a CS/ACK handshake.
//   CLK96, RESET96_N              : clock, async active-low reset
//   PIXEL_CEN, PIXEL_IN, ACTIVE   : pixel strobe, index, display-active flag
//   CPU_CS/WE/BE/ADDR/DIN         : CPU access request
//   CPU_DOUT, CPU_ACK             : CPU read data and completion flag
//   RED, GREEN, BLUE, RGB_ACTIVE  : video output, 2 cycles after the strobe
module bakraid_palette
    import bakraid_video_pkg::*;
#(
    parameter int AW                = PAL_AW,
    parameter int DW                = PAL_DW,
    parameter int BLANK_ON_INACTIVE = 1
) (
    input  logic          CLK96,
    input  logic          RESET96_N,
    input  logic          PIXEL_CEN,
    input  logic [AW-1:0] PIXEL_IN,
    input  logic          ACTIVE,
    input  logic          CPU_CS,
    input  logic          CPU_WE,
    input  logic [1:0]    CPU_BE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_DIN,
    output logic [DW-1:0] CPU_DOUT,
    output logic          CPU_ACK,
    output logic [7:0]    RED,
    output logic [7:0]    GREEN,
    output logic [7:0]    BLUE,
    output logic          RGB_ACTIVE
);

    // ---------------- pixel pipeline ----------------
    // vld_pipe[0]: index registered (RAM read this cycle)
    // vld_pipe[1]: RAM word available (RGB registered this cycle)
    logic [1:0]    vld_pipe;
    logic [AW-1:0] pix_idx;
    logic          pix_act;
    logic          pix_act_d;
    logic [DW-1:0] pal_q;
    logic          pal_unused;

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            vld_pipe  <= '0;
            pix_idx   <= '0;
            pix_act   <= 1'b0;
            pix_act_d <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], PIXEL_CEN};
            if (PIXEL_CEN) begin
                pix_idx <= PIXEL_IN;
                pix_act <= ACTIVE;
            end
            if (vld_pipe[0]) pix_act_d <= pix_act;
        end
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            RED        <= '0;
            GREEN      <= '0;
            BLUE       <= '0;
            RGB_ACTIVE <= 1'b0;
        end else if (vld_pipe[1]) begin
            RGB_ACTIVE <= pix_act_d;
            if (BLANK_ON_INACTIVE != 0 && !pix_act_d) begin
                RED   <= '0;
                GREEN <= '0;
                BLUE  <= '0;
            end else begin
                RED   <= expand5to8(pal_q[R_LSB +: CW]);
                GREEN <= expand5to8(pal_q[G_LSB +: CW]);
                BLUE  <= expand5to8(pal_q[B_LSB +: CW]);
            end
        end
    end

    // Bit 15 is storage only; it never reaches the video output.
    assign pal_unused = pal_q[DW-1];

    // ---------------- CPU access FSM ----------------
    // The request is captured on CS rise so the access completes intact
    // even if CS drops before ACK.
    cpu_state_t    state;
    logic          req_we;
    logic [1:0]    req_be;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_din;
    logic [DW-1:0] cpu_q;

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state    <= S_IDLE;
            CPU_ACK  <= 1'b0;
            CPU_DOUT <= '0;
            req_we   <= 1'b0;
            req_be   <= '0;
            req_addr <= '0;
            req_din  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (CPU_CS && !CPU_ACK) begin
                        req_we   <= CPU_WE;
                        req_be   <= CPU_BE;
                        req_addr <= CPU_ADDR;
                        req_din  <= CPU_DIN;
                        state    <= S_OP;
                    end
                end
                S_OP: begin
                    if (req_we) begin
                        CPU_ACK <= 1'b1;
                        state   <= S_ACK;
                    end else begin
                        state   <= S_RDCAP;
                    end
                end
                S_RDCAP: begin
                    CPU_DOUT <= cpu_q;
                    CPU_ACK  <= 1'b1;
                    state    <= S_ACK;
                end
                S_ACK: begin
                    // Holding here until CS falls is what blocks a re-trigger.
                    if (!CPU_CS) begin
                        CPU_ACK <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    bakraid_pal_dpram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk    (CLK96),
        .a_en   (vld_pipe[0]),
        .a_addr (pix_idx),
        .a_q    (pal_q),
        .b_en   (state == S_OP),
        .b_we   (req_we),
        .b_be   (req_be),
        .b_addr (req_addr),
        .b_din  (req_din),
        .b_q    (cpu_q)
    );

endmodule

// File: tb/tb_bakraid_palette.sv
module tb_bakraid_palette;

    logic        CLK96 = 1'b0;
    logic        RESET96_N = 1'b0;
    logic        PIXEL_CEN = 1'b0;
    logic [10:0] PIXEL_IN = '0;
    logic        ACTIVE = 1'b0;
    logic        CPU_CS = 1'b0;
    logic        CPU_WE = 1'b0;
    logic [1:0]  CPU_BE = '0;
    logic [10:0] CPU_ADDR = '0;
    logic [15:0] CPU_DIN = '0;
    logic [15:0] CPU_DOUT;
    logic        CPU_ACK;
    logic [7:0]  RED, GREEN, BLUE;
    logic        RGB_ACTIVE;

    bakraid_palette dut (
        .CLK96(CLK96), .RESET96_N(RESET96_N),
        .PIXEL_CEN(PIXEL_CEN), .PIXEL_IN(PIXEL_IN), .ACTIVE(ACTIVE),
        .CPU_CS(CPU_CS), .CPU_WE(CPU_WE), .CPU_BE(CPU_BE),
        .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_DOUT(CPU_DOUT), .CPU_ACK(CPU_ACK),
        .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .RGB_ACTIVE(RGB_ACTIVE)
    );

    always #5 CLK96 = ~CLK96;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: palette contents plus which entries are defined.
    logic [15:0] mdl   [2048];
    bit          known [2048];
    int          known_q[$];
    logic [23:0] last_rgb = '0;
    logic        last_act = 1'b0;

    typedef struct {
        logic [10:0] a;
        logic [15:0] d;
        logic [7:0]  r, g, b;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK96);
        #1;
    endtask

    function automatic logic [7:0] x8(input int c5);
        return 8'((c5 * 8) + (c5 / 4));
    endfunction

    function automatic logic [23:0] ref_rgb(input logic [15:0] w, input logic act);
        int v;
        if (!act) return 24'h0;
        v = int'(w);
        return {x8(v % 32), x8((v / 32) % 32), x8((v / 1024) % 32)};
    endfunction

    task automatic mdl_wr(input logic [10:0] a, input logic [15:0] d, input logic [1:0] be);
        if (be[1]) mdl[a][15:8] = d[15:8];
        if (be[0]) mdl[a][7:0]  = d[7:0];
        if (be == 2'b11 && !known[a]) begin
            known[a] = 1'b1;
            known_q.push_back(int'(a));
        end
    endtask

    task automatic cpu_write(input logic [10:0] a, input logic [15:0] d,
                             input logic [1:0] be, input string nm);
        int lat = 0;
        CPU_CS = 1'b1; CPU_WE = 1'b1; CPU_BE = be; CPU_ADDR = a; CPU_DIN = d;
        do begin tick(); lat++; end while (!CPU_ACK && lat < 10);
        chk({nm, " write ack latency"}, lat, 2);
        CPU_CS = 1'b0;
        tick();
        chk({nm, " write ack release"}, {31'b0, CPU_ACK}, 0);
        mdl_wr(a, d, be);
    endtask

    task automatic cpu_read(input logic [10:0] a, input logic [15:0] exp, input string nm);
        int lat = 0;
        CPU_CS = 1'b1; CPU_WE = 1'b0; CPU_BE = 2'b11; CPU_ADDR = a;
        do begin tick(); lat++; end while (!CPU_ACK && lat < 10);
        chk({nm, " read ack latency"}, lat, 3);
        chk({nm, " read data"}, {16'b0, CPU_DOUT}, {16'b0, exp});
        tick();
        chk({nm, " ack held"}, {31'b0, CPU_ACK}, 1);
        CPU_CS = 1'b0;
        tick();
        chk({nm, " read ack release"}, {31'b0, CPU_ACK}, 0);
    endtask

    // Strobe sampled at edge N; output must be unchanged after N+1 and
    // updated after N+2.
    task automatic pixel(input logic [10:0] a, input logic act,
                         input logic [23:0] exp, input string nm);
        PIXEL_IN = a; ACTIVE = act; PIXEL_CEN = 1'b1;
        tick();
        PIXEL_CEN = 1'b0;
        tick();
        chk({nm, " rgb before latency"}, {8'b0, RED, GREEN, BLUE}, {8'b0, last_rgb});
        chk({nm, " active before latency"}, {31'b0, RGB_ACTIVE}, {31'b0, last_act});
        tick();
        chk({nm, " rgb"}, {8'b0, RED, GREEN, BLUE}, {8'b0, exp});
        chk({nm, " rgb_active"}, {31'b0, RGB_ACTIVE}, {31'b0, act});
        last_rgb = exp;
        last_act = act;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        logic [10:0] a;
        logic [15:0] d;
        logic [1:0]  be;

        foreach (known[i]) known[i] = 1'b0;
        foreach (mdl[i])   mdl[i] = '0;

        tbl[0] = '{11'h123, 16'h7FFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[1] = '{11'h010, 16'h0010, 8'h84, 8'h00, 8'h00};
        tbl[2] = '{11'h011, 16'h4000, 8'h00, 8'h00, 8'h84};
        tbl[3] = '{11'h012, 16'h03E0, 8'h00, 8'hFF, 8'h00};
        tbl[4] = '{11'h013, 16'h001F, 8'hFF, 8'h00, 8'h00};
        tbl[5] = '{11'h000, 16'h8421, 8'h08, 8'h08, 8'h08};
        tbl[6] = '{11'h7FF, 16'h0000, 8'h00, 8'h00, 8'h00};

        // reset state
        tick(); tick();
        chk("reset rgb", {8'b0, RED, GREEN, BLUE}, 0);
        chk("reset ack", {31'b0, CPU_ACK}, 0);
        chk("reset dout", {16'b0, CPU_DOUT}, 0);
        chk("reset rgb_active", {31'b0, RGB_ACTIVE}, 0);
        RESET96_N = 1'b1;
        tick();

        // table: write entry, look it up, compare against table colour
        for (int i = 0; i < 7; i++) begin
            cpu_write(tbl[i].a, tbl[i].d, 2'b11, $sformatf("tbl%0d", i));
            pixel(tbl[i].a, 1'b1, {tbl[i].r, tbl[i].g, tbl[i].b}, $sformatf("tbl%0d", i));
        end

        // blanking
        pixel(11'h123, 1'b0, 24'h0, "blank");

        // byte enables
        cpu_write(11'h045, 16'h1234, 2'b11, "be full");
        cpu_write(11'h045, 16'hAB00, 2'b10, "be upper");
        cpu_read(11'h045, 16'hAB34, "be readback");
        cpu_write(11'h045, 16'hFFFF, 2'b00, "be none");
        cpu_read(11'h045, 16'hAB34, "be none readback");
        cpu_write(11'h045, 16'h00CD, 2'b01, "be lower");
        cpu_read(11'h045, 16'hABCD, "be lower readback");

        // collision: lookup and write to 0x200 on the same edge -> old data
        cpu_write(11'h200, 16'h001F, 2'b11, "coll pre");
        CPU_CS = 1'b1; CPU_WE = 1'b1; CPU_BE = 2'b11; CPU_ADDR = 11'h200; CPU_DIN = 16'h03E0;
        PIXEL_IN = 11'h200; ACTIVE = 1'b1; PIXEL_CEN = 1'b1;
        tick();
        PIXEL_CEN = 1'b0;
        tick();
        chk("coll ack", {31'b0, CPU_ACK}, 1);
        tick();
        chk("coll old rgb", {8'b0, RED, GREEN, BLUE}, 32'h00FF0000);
        last_rgb = 24'hFF0000; last_act = 1'b1;
        CPU_CS = 1'b0;
        tick(); tick();
        mdl_wr(11'h200, 16'h03E0, 2'b11);
        pixel(11'h200, 1'b1, 24'h00FF00, "coll new");

        // CS held for 20 cycles: one write, DIN change mid-hold ignored
        CPU_CS = 1'b1; CPU_WE = 1'b1; CPU_BE = 2'b11; CPU_ADDR = 11'h300; CPU_DIN = 16'h2468;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 9) CPU_DIN = 16'h1111;
            if (CPU_ACK) acks++;
        end
        chk("hold ack cycles", acks, 19);
        CPU_CS = 1'b0;
        tick();
        chk("hold ack release", {31'b0, CPU_ACK}, 0);
        mdl_wr(11'h300, 16'h2468, 2'b11);
        cpu_read(11'h300, 16'h2468, "hold readback");

        // CS dropped the cycle after rise
        CPU_CS = 1'b1; CPU_WE = 1'b1; CPU_BE = 2'b11; CPU_ADDR = 11'h301; CPU_DIN = 16'h1357;
        tick();
        CPU_CS = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (CPU_ACK) acks++;
        end
        chk("drop ack pulse", acks, 1);
        mdl_wr(11'h301, 16'h1357, 2'b11);
        cpu_read(11'h301, 16'h1357, "drop readback");

        // reset mid-frame with ACK high and RGB non-zero
        pixel(11'h123, 1'b1, 24'hFFFFFF, "pre reset");
        CPU_CS = 1'b1; CPU_WE = 1'b0; CPU_BE = 2'b11; CPU_ADDR = 11'h123;
        tick(); tick(); tick();
        chk("pre reset ack", {31'b0, CPU_ACK}, 1);
        #2 RESET96_N = 1'b0;
        #1;
        chk("async reset rgb", {8'b0, RED, GREEN, BLUE}, 0);
        chk("async reset ack", {31'b0, CPU_ACK}, 0);
        chk("async reset dout", {16'b0, CPU_DOUT}, 0);
        chk("async reset rgb_active", {31'b0, RGB_ACTIVE}, 0);
        CPU_CS = 1'b0;
        tick(); tick();
        RESET96_N = 1'b1;
        tick();
        last_rgb = '0; last_act = 1'b0;
        pixel(11'h123, 1'b1, 24'hFFFFFF, "post reset");

        // reset between CS rise and the RAM write: write lost
        cpu_write(11'h124, 16'h1111, 2'b11, "lost pre");
        CPU_CS = 1'b1; CPU_WE = 1'b1; CPU_BE = 2'b11; CPU_ADDR = 11'h124; CPU_DIN = 16'h5555;
        tick();
        #2 RESET96_N = 1'b0;
        CPU_CS = 1'b0;
        tick(); tick();
        RESET96_N = 1'b1;
        tick();
        last_rgb = '0; last_act = 1'b0;
        cpu_read(11'h124, 16'h1111, "lost write");

        // randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a  = 11'($urandom_range(0, 2047));
                    d  = 16'($urandom);
                    be = known[a] ? 2'($urandom_range(0, 3)) : 2'b11;
                    cpu_write(a, d, be, "rnd");
                end
                1: begin
                    a = 11'(known_q[$urandom_range(0, known_q.size() - 1)]);
                    cpu_read(a, mdl[a], "rnd");
                end
                default: begin
                    logic act;
                    a   = 11'(known_q[$urandom_range(0, known_q.size() - 1)]);
                    act = 1'($urandom_range(0, 1));
                    pixel(a, act, ref_rgb(mdl[a], act), "rnd");
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
